mux_mem_responder: RTL and testbench

- Memory-side responder for the mux_mem interface: accepts the mux's mem_cmd/mem_addr/mem_wr_data and serves them from an on-chip single-port block RAM of 32-bit words.
- Guarantees the one-cycle read timing the mux relies on:
  - cmd sampled at edge E1 -> mem_rd_data stable before E2;
  - mem_rd_data held until the next read.
- After every reset it runs a fill sweep that writes FILL_VALUE to every word, so the cart and USB sides never read stale contents.

---
 rtl/gba_io_fpga_header.sv | 22 ++
 rtl/mux_mem_interface.sv | 34 +++
 rtl/spram_32.sv | 34 +++
 rtl/mux_mem_responder.sv | 147 ++++++++++++++
 tb/tb_mux_mem_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/gba_io_fpga_header.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gba_io_fpga_header                                         |
// | Brief   : Shared package for the mux_mem path: command encoding and  |
// |           default memory address width.                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package gba_io_fpga_header;

  // Word-address width of the on-chip memory (2^17 words x 32 b = 512 KiB).
  localparam int MEM_ADDR_WIDTH = 17;

  // Command issued by the mux towards the memory responder.
  typedef enum logic [1:0] {
    CMD_IDLE    = 2'b00,
    CMD_READ    = 2'b01,
    CMD_WRITE   = 2'b10,
    CMD_ILLEGAL = 2'b11
  } mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/mux_mem_interface.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mux_mem_interface                                          |
// | Brief   : Mux-to-memory command/data bundle with mux (master) and    |
// |           responder (mem) views.                                     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface mux_mem_interface #(
  parameter int ADDR_WIDTH = gba_io_fpga_header::MEM_ADDR_WIDTH
) ();

  gba_io_fpga_header::mem_cmd_t mem_cmd;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [31:0]                  mem_wr_data;
  logic [31:0]                  mem_rd_data;

  // Mux side: issues commands, consumes read data.
  modport master (
    output mem_cmd,
    output mem_addr,
    output mem_wr_data,
    input  mem_rd_data
  );

  // Responder side: consumes commands, returns read data.
  modport mem (
    input  mem_cmd,
    input  mem_addr,
    input  mem_wr_data,
    output mem_rd_data
  );

endinterface
`default_nettype wire

// File: rtl/spram_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spram_32                                                   |
// | Brief   : Single-port 32-bit RAM, synchronous read-first, no reset   |
// |           on the array so it maps onto block RAM.                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module spram_32 #(
  parameter int ADDR_WIDTH = 17
) (
  input  wire logic                  clk,
  input  wire logic                  en,
  input  wire logic                  we,
  input  wire logic [ADDR_WIDTH-1:0] addr,
  input  wire logic [31:0]           din,
  output logic      [31:0]           dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [0:DEPTH-1];

  // Enabled access: optional write, and the old word is always read out.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= din;
      end
      dout <= r_mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mux_mem_responder                                          |
// | Brief   : Memory-side responder for the mux_mem interface. Sweeps    |
// |           FILL_VALUE into every word after reset, then serves        |
// |           1-cycle reads and writes from a single-port RAM.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mux_mem_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] FILL_VALUE = 32'h0000_0000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mux_mem_interface.mem  mux_mem,
  output logic           init_done,
  output logic           cmd_err
);

  import gba_io_fpga_header::*;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;

  logic [ADDR_WIDTH-1:0] r_fill_addr;
  logic                  w_fill_last;

  logic                  r_init_done;
  logic                  r_cmd_err;

  // A read sampled at the last edge leaves its word on the RAM output;
  // one edge later that word is copied into the hold register so that
  // later writes (which also clock the RAM output) cannot disturb it.
  logic                  r_rd_pending;
  logic [31:0]           r_rd_hold;

  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [31:0]           w_ram_din;
  logic [31:0]           w_ram_dout;
  logic                  w_rd_issue;
  logic                  w_err_set;

  assign w_fill_last = (r_fill_addr == c_last_addr);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave the sweep once the last word has been written.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL:  if (w_fill_last) w_state_next = ST_SERVE;
      ST_SERVE: w_state_next = ST_SERVE;
      default:  w_state_next = ST_FILL;
    endcase
  end

  // Outputs: steer either the fill sweep or the mux command onto the RAM.
  always_comb begin
    w_ram_en   = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_addr = mux_mem.mem_addr;
    w_ram_din  = mux_mem.mem_wr_data;
    w_rd_issue = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_ram_en   = 1'b1;
        w_ram_we   = 1'b1;
        w_ram_addr = r_fill_addr;
        w_ram_din  = FILL_VALUE;
        w_err_set  = (mux_mem.mem_cmd != CMD_IDLE);
      end
      ST_SERVE: begin
        case (mux_mem.mem_cmd)
          CMD_READ: begin
            w_ram_en   = 1'b1;
            w_rd_issue = 1'b1;
          end
          CMD_WRITE: begin
            w_ram_en = 1'b1;
            w_ram_we = 1'b1;
          end
          CMD_ILLEGAL: w_err_set = 1'b1;
          default:     w_err_set = 1'b0;
        endcase
      end
      default: w_err_set = 1'b0;
    endcase
  end

  // Sweep counter, status flags and read-data hold path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_addr  <= '0;
      r_init_done  <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_rd_pending <= 1'b0;
      r_rd_hold    <= '0;
    end else begin
      if (r_state == ST_FILL) begin
        // Wraps to 0 on the final increment and stays there in SERVE.
        r_fill_addr <= r_fill_addr + ADDR_WIDTH'(1);
        if (w_fill_last) begin
          r_init_done <= 1'b1;
        end
      end
      if (w_err_set) begin
        r_cmd_err <= 1'b1;
      end
      r_rd_pending <= w_rd_issue;
      if (r_rd_pending) begin
        r_rd_hold <= w_ram_dout;
      end
    end
  end

  spram_32 #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (w_ram_en),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .din  (w_ram_din),
    .dout (w_ram_dout)
  );

  assign mux_mem.mem_rd_data = r_rd_pending ? w_ram_dout : r_rd_hold;
  assign init_done           = r_init_done;
  assign cmd_err             = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mux_mem_responder                                       |
// | Brief   : Directed self-checking bench for mux_mem_responder with a  |
// |           read-data scoreboard queue.                                |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_mux_mem_responder;

  import gba_io_fpga_header::*;

  localparam int          AW   = 4;
  localparam logic [31:0] FILL = 32'hA5A5_A5A5;

  logic clk;
  logic rst;
  logic init_done;
  logic cmd_err;

  mux_mem_interface #(.ADDR_WIDTH(AW)) mux_mem ();

  mux_mem_responder #(
    .ADDR_WIDTH (AW),
    .FILL_VALUE (FILL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mux_mem   (mux_mem),
    .init_done (init_done),
    .cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mem_cmd_t cmd, input logic [AW-1:0] addr, input logic [31:0] data);
    mux_mem.mem_cmd     = cmd;
    mux_mem.mem_addr    = addr;
    mux_mem.mem_wr_data = data;
  endtask

  // Issue a read and record the word it must return.
  task automatic push_read(input logic [AW-1:0] addr, input logic [31:0] exp);
    drive(CMD_READ, addr, 32'h0);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, mux_mem.mem_rd_data);
    end else begin
      e = exp_q.pop_front();
      check(tag, mux_mem.mem_rd_data, e);
    end
  endtask

  // Count edges until init_done rises, bounded.
  task automatic wait_init(inout int n);
    for (int i = 0; i < 64 && !init_done; i++) begin
      step();
      n++;
    end
  endtask

  int n_edges;

  initial begin
    rst = 1'b1;
    drive(CMD_IDLE, '0, 32'h0);
    step();
    step();
    check("reset_rd_data", mux_mem.mem_rd_data, 32'h0);
    check("reset_init_done", {31'h0, init_done}, 32'h0);
    check("reset_cmd_err", {31'h0, cmd_err}, 32'h0);

    // Fill sweep length.
    rst = 1'b0;
    n_edges = 0;
    wait_init(n_edges);
    check("fill_cycles", n_edges, 32'd16);
    check("fill_cmd_err", {31'h0, cmd_err}, 32'h0);

    // Every word holds the fill value; back-to-back reads.
    for (int a = 0; a < 16; a++) begin
      push_read(AW'(a), FILL);
      step();
      sb_check($sformatf("fill_read_%0d", a));
    end

    // Mux-timed read then hold.
    drive(CMD_WRITE, 4'd3, 32'h1234_5678);
    step();
    push_read(4'd3, 32'h1234_5678);
    step();
    sb_check("read3");
    drive(CMD_IDLE, '0, 32'h0);
    repeat (5) step();
    check("read3_hold", mux_mem.mem_rd_data, 32'h1234_5678);

    // Write then read same address on the next edge.
    drive(CMD_WRITE, 4'd5, 32'hDEAD_BEEF);
    step();
    push_read(4'd5, 32'hDEAD_BEEF);
    step();
    sb_check("wr_then_rd5");
    // Read then write same address: data shows the old word and holds.
    push_read(4'd5, 32'hDEAD_BEEF);
    step();
    sb_check("rd_then_wr5_a");
    drive(CMD_WRITE, 4'd5, 32'h0);
    step();
    check("rd_then_wr5_b", mux_mem.mem_rd_data, 32'hDEAD_BEEF);
    push_read(4'd5, 32'h0);
    step();
    sb_check("rd5_after_wr0");

    // Read-modify-write on addr 2.
    drive(CMD_WRITE, 4'd2, 32'h1122_3344);
    step();
    push_read(4'd2, 32'h1122_3344);
    step();
    sb_check("rmw_read");
    drive(CMD_IDLE, '0, 32'h0);
    step();
    drive(CMD_WRITE, 4'd2, 32'h11AA_3344);
    step();
    push_read(4'd2, 32'h11AA_3344);
    step();
    sb_check("rmw_result");
    push_read(4'd1, FILL);
    step();
    sb_check("rmw_neigh1");
    push_read(4'd3, 32'h1234_5678);
    step();
    sb_check("rmw_neigh3");

    // Illegal command in SERVE.
    drive(CMD_ILLEGAL, 4'd2, 32'h0);
    step();
    check("illegal_err", {31'h0, cmd_err}, 32'h1);
    check("illegal_hold", mux_mem.mem_rd_data, 32'h1234_5678);
    push_read(4'd2, 32'h11AA_3344);
    step();
    sb_check("illegal_ram_intact");
    drive(CMD_IDLE, '0, 32'h0);
    step();
    check("err_sticky", {31'h0, cmd_err}, 32'h1);

    // Fresh reset, write attempted during the sweep.
    rst = 1'b1;
    step();
    check("rst2_err_clear", {31'h0, cmd_err}, 32'h0);
    check("rst2_rd_clear", mux_mem.mem_rd_data, 32'h0);
    rst = 1'b0;
    n_edges = 0;
    step();
    step();
    n_edges = 2;
    drive(CMD_WRITE, 4'd0, 32'h0);
    step();
    n_edges++;
    drive(CMD_IDLE, '0, 32'h0);
    check("fill_cmd_err_set", {31'h0, cmd_err}, 32'h1);
    wait_init(n_edges);
    check("fill2_cycles", n_edges, 32'd16);
    push_read(4'd0, FILL);
    step();
    sb_check("fill_write_dropped");

    // Reset in the middle of a sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    drive(CMD_ILLEGAL, '0, 32'h0);
    step();
    drive(CMD_IDLE, '0, 32'h0);
    repeat (5) step();
    check("midsweep_err_before", {31'h0, cmd_err}, 32'h1);
    check("midsweep_not_done", {31'h0, init_done}, 32'h0);
    rst = 1'b1;
    step();
    check("midsweep_init_done", {31'h0, init_done}, 32'h0);
    check("midsweep_cmd_err", {31'h0, cmd_err}, 32'h0);
    check("midsweep_rd_data", mux_mem.mem_rd_data, 32'h0);
    rst = 1'b0;
    n_edges = 0;
    wait_init(n_edges);
    check("midsweep_fill_cycles", n_edges, 32'd16);
    push_read(4'd9, FILL);
    step();
    sb_check("midsweep_read9");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
